// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM stage register: control bundle,
// default-width payload view, store-size encodings and a control-gating helper.
package ex_mem_pkg;

    localparam int EX_MEM_XLEN       = 32;
    localparam int EX_MEM_REG_ADDR_W = 5;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    typedef struct packed {
        logic reg_write;
        logic mem_reg;
        logic mem_read;
        logic mem_write;
    } ex_mem_ctrl_t;

    typedef struct packed {
        ex_mem_ctrl_t                 ctrl;
        logic [EX_MEM_XLEN-1:0]       alu_result;
        logic [EX_MEM_XLEN-1:0]       store_data;
        logic [EX_MEM_REG_ADDR_W-1:0] rd_addr;
        logic [1:0]                   size;
    } ex_mem_payload_t;

    // Controls are only meaningful while the entry they belong to is valid
    function automatic ex_mem_ctrl_t gate_ctrl(input ex_mem_ctrl_t ctrl, input logic valid);
        ex_mem_ctrl_t g;
        if (valid) begin
            g = ctrl;
        end else begin
            g = ex_mem_ctrl_t'(4'b0000);
        end
        return g;
    endfunction

endpackage

// File: rtl/ex_mem_store_align.sv
// Store lane alignment: byte enables and shifted store data from size and the
// low address bits. Only instantiated when STORE_MASK_EN is defined.
module ex_mem_store_align
    import ex_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]        size_i,
    input  logic [1:0]        addr_i,
    input  logic [XLEN-1:0]   data_i,
    input  logic              write_i,
    output logic [XLEN/8-1:0] be_o,
    output logic [XLEN-1:0]   data_o
);

    localparam int BE_W = XLEN / 8;

    logic [BE_W-1:0] be_raw_s;

    // Half-word stores ignore addr[0]; unknown sizes enable no lanes
    always_comb begin
        be_raw_s = '0;
        data_o   = data_i;
        case (size_i)
            MEM_SIZE_BYTE: begin
                be_raw_s = BE_W'(1) << addr_i;
                data_o   = XLEN'(data_i[7:0]) << {addr_i, 3'b000};
            end
            MEM_SIZE_HALF: begin
                be_raw_s = BE_W'(3) << {addr_i[1], 1'b0};
                data_o   = XLEN'(data_i[15:0]) << {addr_i[1], 4'b0000};
            end
            MEM_SIZE_WORD: begin
                be_raw_s = '1;
                data_o   = data_i;
            end
            default: begin
                be_raw_s = '0;
                data_o   = data_i;
            end
        endcase
    end

    assign be_o = write_i ? be_raw_s : '0;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// Elastic EX/MEM pipeline register with valid/ready handshake, flush, optional
// skid entry (SKID), forwarding taps and a saturating stall counter.
// Define STORE_MASK_EN to add mem_be_o and lane-aligned store data.
module ex_mem_stage_reg
    import ex_mem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int SKID        = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   reg_write_i,
    input  logic                   mem_reg_i,
    input  logic                   mem_read_i,
    input  logic                   mem_write_i,
    input  logic [XLEN-1:0]        alu_result_i,
    input  logic [XLEN-1:0]        rs2_data_i,
    input  logic [REG_ADDR_W-1:0]  rd_addr_i,
    input  logic [1:0]             mem_size_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   reg_write_o,
    output logic                   mem_reg_o,
    output logic                   mem_read_o,
    output logic                   mem_write_o,
    output logic [XLEN-1:0]        alu_result_o,
    output logic [XLEN-1:0]        mem_data_o,
    output logic [REG_ADDR_W-1:0]  rd_addr_o,
    output logic                   fwd_valid_o,
    output logic [REG_ADDR_W-1:0]  fwd_rd_addr_o,
    output logic [XLEN-1:0]        fwd_data_o,
`ifdef STORE_MASK_EN
    output logic [XLEN/8-1:0]      mem_be_o,
`endif
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    // Parameterised counterpart of ex_mem_payload_t
    typedef struct packed {
        ex_mem_ctrl_t          ctrl;
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       store_data;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [1:0]            size;
    } entry_t;

    entry_t                 main_q, main_d, skid_q, skid_d, in_entry_s;
    logic                   main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   accept_s, retire_s;
    ex_mem_ctrl_t           ctrl_out_s;

    if (SKID != 0) begin : g_skid
        assign in_ready_o = !skid_v_q;
    end else begin : g_noskid
        assign in_ready_o = !main_v_q | out_ready_i;
    end

    assign accept_s = in_valid_i & in_ready_o;
    assign retire_s = main_v_q & out_ready_i;

    // Capture: x0 is never written back, so its reg_write is dropped here
    always_comb begin
        in_entry_s.ctrl.reg_write = reg_write_i & (|rd_addr_i);
        in_entry_s.ctrl.mem_reg   = mem_reg_i;
        in_entry_s.ctrl.mem_read  = mem_read_i;
        in_entry_s.ctrl.mem_write = mem_write_i;
        in_entry_s.alu_result     = alu_result_i;
        in_entry_s.store_data     = rs2_data_i;
        in_entry_s.rd_addr        = rd_addr_i;
        in_entry_s.size           = mem_size_i;
    end

    // Main entry refills from skid first so order is preserved; flush drops all
    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (flush_i) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || retire_s) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else if (accept_s) begin
                main_d   = in_entry_s;
                main_v_d = 1'b1;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (accept_s && (SKID != 0)) begin
            skid_d   = in_entry_s;
            skid_v_d = 1'b1;
        end else begin
            skid_v_d = skid_v_q;
        end
    end

    // Stall counter saturates at all-ones; only reset clears it
    always_comb begin
        if (main_v_q && !out_ready_i && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stage state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_q      <= '0;
            skid_q      <= '0;
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            main_q      <= main_d;
            skid_q      <= skid_d;
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ctrl_out_s    = gate_ctrl(main_q.ctrl, main_v_q);
    assign out_valid_o   = main_v_q;
    assign reg_write_o   = ctrl_out_s.reg_write;
    assign mem_reg_o     = ctrl_out_s.mem_reg;
    assign mem_read_o    = ctrl_out_s.mem_read;
    assign mem_write_o   = ctrl_out_s.mem_write;
    assign alu_result_o  = main_q.alu_result;
    assign rd_addr_o     = main_q.rd_addr;
    assign fwd_valid_o   = main_v_q & ctrl_out_s.reg_write;
    assign fwd_rd_addr_o = main_q.rd_addr;
    assign fwd_data_o    = main_q.alu_result;
    assign stall_cnt_o   = stall_cnt_q;

`ifdef STORE_MASK_EN
    ex_mem_store_align #(
        .XLEN(XLEN)
    ) u_store_align (
        .size_i (main_q.size),
        .addr_i (main_q.alu_result[1:0]),
        .data_i (main_q.store_data),
        .write_i(ctrl_out_s.mem_write),
        .be_o   (mem_be_o),
        .data_o (mem_data_o)
    );
`else
    logic unused_size_s;
    assign unused_size_s = ^main_q.size;
    assign mem_data_o    = main_q.store_data;
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Randomised and directed bench for ex_mem_stage_reg (SKID=1) against a
// queue-based model of a two-deep in-order buffer.
module tb_ex_mem_stage_reg;
    import ex_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        reg_write = 1'b0, mem_reg = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] alu = 32'h0, rs2 = 32'h0;
    logic [4:0]  rd = 5'h0;
    logic [1:0]  size = 2'b00;
    logic        in_ready, out_valid, rw_o, mreg_o, mrd_o, mwr_o, fwd_v;
    logic [31:0] alu_o, data_o, fwd_d;
    logic [4:0]  rd_o, fwd_rd;
    logic [15:0] stall;
`ifdef STORE_MASK_EN
    logic [3:0]  be_o;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_mem_stage_reg dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .reg_write_i(reg_write), .mem_reg_i(mem_reg), .mem_read_i(mem_read), .mem_write_i(mem_write),
        .alu_result_i(alu), .rs2_data_i(rs2), .rd_addr_i(rd), .mem_size_i(size),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .reg_write_o(rw_o), .mem_reg_o(mreg_o), .mem_read_o(mrd_o), .mem_write_o(mwr_o),
        .alu_result_o(alu_o), .mem_data_o(data_o), .rd_addr_o(rd_o),
        .fwd_valid_o(fwd_v), .fwd_rd_addr_o(fwd_rd), .fwd_data_o(fwd_d),
`ifdef STORE_MASK_EN
        .mem_be_o(be_o),
`endif
        .stall_cnt_o(stall)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        bit        rw, mreg, mrd, mwr;
        bit [31:0] alu, st;
        bit [4:0]  rd;
        bit [1:0]  sz;
    } ent_t;

    ent_t q[$];
    ent_t shown;
    ent_t e;
    int   m_stall;
    bit   acc, ret, v;

    function automatic bit [31:0] exp_data(ent_t x);
`ifdef STORE_MASK_EN
        case (x.sz)
            2'd0: return (x.st & 32'hFF) << (8 * x.alu[1:0]);
            2'd1: return (x.st & 32'hFFFF) << (16 * x.alu[1]);
            default: return x.st;
        endcase
`else
        return x.st;
`endif
    endfunction

`ifdef STORE_MASK_EN
    function automatic bit [3:0] exp_be(ent_t x, bit valid);
        if (!(valid && x.mwr)) return 4'h0;
        case (x.sz)
            2'd0: return 4'h1 << x.alu[1:0];
            2'd1: return 4'h3 << (2 * x.alu[1]);
            2'd2: return 4'hF;
            default: return 4'h0;
        endcase
    endfunction
`endif

    // Model: up to two queued instructions, head visible; compared every negedge
    initial forever begin
        @(negedge clk);
        if (rst) begin
            q.delete();
            m_stall = 0;
            shown = '0;
        end else begin
            acc = in_valid && (q.size() < 2);
            ret = (q.size() > 0) && out_ready;
            if (q.size() > 0 && !out_ready && m_stall < 65535) m_stall++;
            if (ret) void'(q.pop_front());
            if (flush) begin
                q.delete();
            end else if (acc) begin
                e.rw = reg_write && (rd != 5'd0);
                e.mreg = mem_reg; e.mrd = mem_read; e.mwr = mem_write;
                e.alu = alu; e.st = rs2; e.rd = rd; e.sz = size;
                q.push_back(e);
            end
            if (q.size() > 0) shown = q[0];
            v = q.size() > 0;
            chk("in_ready", in_ready, q.size() < 2);
            chk("out_valid", out_valid, v);
            chk("reg_write_o", rw_o, v & shown.rw);
            chk("mem_reg_o", mreg_o, v & shown.mreg);
            chk("mem_read_o", mrd_o, v & shown.mrd);
            chk("mem_write_o", mwr_o, v & shown.mwr);
            chk("alu_result_o", alu_o, shown.alu);
            chk("mem_data_o", data_o, exp_data(shown));
            chk("rd_addr_o", rd_o, shown.rd);
            chk("fwd_valid_o", fwd_v, v & shown.rw);
            chk("fwd_rd_addr_o", fwd_rd, shown.rd);
            chk("fwd_data_o", fwd_d, shown.alu);
            chk("stall_cnt_o", stall, m_stall[15:0]);
`ifdef STORE_MASK_EN
            chk("mem_be_o", be_o, exp_be(shown, v));
`endif
        end
    end

    task automatic drive(input bit vld, input bit [4:0] r, input bit [31:0] a,
                         input bit rwv, input bit ordy, input bit fl);
        in_valid = vld; rd = r; alu = a; rs2 = a ^ 32'hFFFF0000;
        reg_write = rwv; mem_reg = 1'b1; mem_read = 1'b1; mem_write = 1'b1;
        size = 2'b10; out_ready = ordy; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_stall", stall, 16'h0);
        chk("reset_alu", alu_o, 32'h0);

        // Single instruction
        drive(1'b1, 5'd5, 32'h10, 1'b1, 1'b1, 1'b0); tick();
        chk("single_valid", out_valid, 1'b1);
        chk("single_alu", alu_o, 32'h10);
        chk("single_fwd_valid", fwd_v, 1'b1);
        chk("single_fwd_rd", fwd_rd, 5'd5);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
        chk("single_retired", out_valid, 1'b0);
        chk("single_hold_alu", alu_o, 32'h10);

        // Back-pressure A, B, C
        drive(1'b1, 5'd1, 32'hA, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd2, 32'hB, 1'b1, 1'b0, 1'b0); tick();
        chk("bp_full_ready", in_ready, 1'b0);
        drive(1'b1, 5'd3, 32'hC, 1'b1, 1'b0, 1'b0); tick(); tick(); tick();
        chk("bp_stall_cnt", stall, 16'd4);
        chk("bp_hold_A", alu_o, 32'hA);
        chk("bp_still_full", in_ready, 1'b0);
        drive(1'b1, 5'd3, 32'hC, 1'b1, 1'b1, 1'b0); tick();
        chk("bp_out_B", alu_o, 32'hB);
        chk("bp_ready_again", in_ready, 1'b1);
        tick();
        chk("bp_out_C", alu_o, 32'hC);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
        chk("bp_drained", out_valid, 1'b0);
        chk("bp_stall_final", stall, 16'd4);

        // Flush while FULL with D presented
        drive(1'b1, 5'd6, 32'h60, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd7, 32'h70, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd8, 32'hD0, 1'b1, 1'b0, 1'b1); tick();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ctrl", {rw_o, mreg_o, mrd_o, mwr_o, fwd_v}, 5'b00000);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0); tick(); tick();
        chk("flush_no_D", out_valid, 1'b0);
        chk("flush_hold_alu", alu_o, 32'h60);
        chk("flush_stall", stall, 16'd6);

        // x0 destination
        drive(1'b1, 5'd0, 32'h40, 1'b1, 1'b1, 1'b0); tick();
        chk("x0_valid", out_valid, 1'b1);
        chk("x0_reg_write", rw_o, 1'b0);
        chk("x0_fwd_valid", fwd_v, 1'b0);
        chk("x0_mem_reg", mreg_o, 1'b1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0); tick();

        // Asynchronous reset mid-stall
        drive(1'b1, 5'd9, 32'h90, 1'b1, 1'b0, 1'b0); tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("areset_valid", out_valid, 1'b0);
        chk("areset_stall", stall, 16'h0);
        chk("areset_alu", alu_o, 32'h0);
        chk("areset_ready", in_ready, 1'b1);
        chk("areset_ctrl", {rw_o, mreg_o, mrd_o, mwr_o, fwd_v}, 5'b00000);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = $urandom_range(0, 99) < 70;
            rd        = 5'($urandom_range(0, 31));
            alu       = $urandom;
            rs2       = $urandom;
            reg_write = 1'($urandom_range(0, 1));
            mem_reg   = 1'($urandom_range(0, 1));
            mem_read  = 1'($urandom_range(0, 1));
            mem_write = 1'($urandom_range(0, 1));
            size      = 2'($urandom_range(0, 3));
            out_ready = ((i / 200) % 4 == 3) ? 1'b0 : ($urandom_range(0, 99) < 60);
            flush     = $urandom_range(0, 99) < 4;
            tick();
        end

        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage_reg.md
Name: ex_mem_stage_reg

Overview:
Parametrised, elastic EX/MEM pipeline stage register for the core, replacing the fixed free-running latch. Carries a valid bit with a valid/ready handshake, supports stall (back-pressure) and flush, and can use an optional skid entry to break the combinational ready path. Exposes forwarding taps to the hazard unit and a saturating stall counter for performance debug.

Parameters:
XLEN, 32, width of ALU result and store data
REG_ADDR_W, 5, destination register address width
SKID, 1, 1 = two-entry skid buffer with registered in_ready_o; 0 = single entry with combinational ready
STALL_CNT_W, 16, width of saturating stall counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
flush_i  in  1  invalidate all held entries and drop the current input
in_valid_i  in  1  EX presents an instruction
in_ready_o  out  1  stage can accept this cycle
reg_write_i, mem_reg_i, mem_read_i, mem_write_i  in  1 each  control bundle
alu_result_i  in  XLEN  ALU result / memory address
rs2_data_i  in  XLEN  store data
rd_addr_i  in  REG_ADDR_W  destination register
mem_size_i  in  2  00 byte, 01 half, 10 word (used only with STORE_MASK_EN)
out_valid_o  out  1  MEM stage entry valid
out_ready_i  in  1  MEM accepts this cycle
reg_write_o, mem_reg_o, mem_read_o, mem_write_o  out  1 each  gated control
alu_result_o, mem_data_o  out  XLEN  registered result / store data
rd_addr_o  out  REG_ADDR_W  registered destination
fwd_valid_o, fwd_rd_addr_o, fwd_data_o  out  1/REG_ADDR_W/XLEN  forwarding tap: out_valid_o & reg_write_o, rd_addr_o, alu_result_o
stall_cnt_o  out  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (async, rst_i=1): all valid bits 0, all data/control/address registers 0, stall_cnt_o 0. in_ready_o = 1 after reset.
- Accept = in_valid_i & in_ready_o. Retire = out_valid_o & out_ready_i. Latency 1 cycle, throughput 1 per cycle.
- SKID=0: in_ready_o = !out_valid_o | out_ready_i (combinational). On accept, main entry loads the input.
- SKID=1: in_ready_o = !skid_valid (registered). States: EMPTY (main 0, skid 0), ONE (main 1, skid 0), FULL (main 1, skid 1).
  EMPTY: accept -> ONE.
  ONE: accept & retire -> ONE (main reloads); accept & !retire -> FULL (input goes to skid); retire only -> EMPTY.
  FULL: retire -> ONE (skid moves to main); no input is accepted while FULL.
- Order is preserved in all cases. Main-entry data holds while out_valid_o & !out_ready_i.
- Capture rule: if rd_addr_i == 0, reg_write is stored as 0 (x0 never written or forwarded).
- Output gating: reg_write_o, mem_read_o, mem_write_o and mem_reg_o = 0 whenever out_valid_o = 0. Data outputs hold their last value.
- flush_i (synchronous, highest priority): next cycle, all valid bits are 0 and the state is EMPTY, and any same-cycle input is dropped. A retire in the flush cycle still completes, because MEM sampled it. in_ready_o is not affected by flush_i in the same cycle.
- Simultaneous flush_i and rst_i: reset wins.
- Reset mid-operation: entries are lost with no partial outputs, and all outputs go to their reset values immediately.
- stall_cnt_o: increments when out_valid_o & !out_ready_i, saturates at all-ones, and is cleared only by reset.

Optional Feature:
- Macro STORE_MASK_EN. Defined: adds output mem_be_o[XLEN/8], and mem_data_o is shifted by alu_result_i[1:0].
  - byte: be = 1 << addr[1:0], data replicated in lane.
  - half: be = 0011 << addr[1], with addr[0] ignored.
  - word: be = 1111.
  - mem_be_o is 0 when mem_write_o = 0.
- Undefined: no mem_be_o port, mem_data_o = rs2_data_i unmodified, and mem_size_i is ignored.

Decomposition:
- Shared package ex_mem_pkg holds:
  - typedef ex_mem_ctrl_t (reg_write, mem_reg, mem_read, mem_write)
  - typedef ex_mem_payload_t (ctrl, alu_result, store data, rd_addr, size)
  - MEM_SIZE_BYTE/HALF/WORD constants
- One sub-module is natural: ex_mem_store_align (combinational byte-enable/shift, instantiated only under STORE_MASK_EN).

Test Plan:
- Reset then single instruction: rd=5, alu=0x10, reg_write=1, out_ready=1 -> out_valid_o high 1 cycle later with alu_result_o=0x10, fwd_valid_o=1, fwd_rd_addr_o=5.
- Back-pressure, SKID=1: stream A, B, C with out_ready_i=0 from cycle 1 -> A held, B in skid, in_ready_o=0, C held upstream. Raising out_ready then yields A, B, C in order, with stall_cnt_o equal to the stalled cycles.
- Flush while FULL with simultaneous valid input D -> next cycle out_valid_o=0, all gated controls 0, D never appears.
- rd_addr_i=0 with reg_write_i=1 -> reg_write_o=0 and fwd_valid_o=0 while out_valid_o=1.
- Async reset asserted mid-stall between clock edges -> outputs go to 0 immediately without a clock edge, and stall_cnt_o=0.
- STORE_MASK_EN: byte store of rs2=0x000000AB at addr 0x3 -> mem_be_o=1000, mem_data_o=0xAB000000. Half store at 0x2 -> mem_be_o=1100.
